// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM states, byte width
// and a constant-friendly clog2 helper.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } tx_state_e;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((32'sd1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority pick: the first requester at or above the
// pointer wins, wrapping modulo N.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  localparam logic [N-1:0] ONE_HOT_LSB = {{(N-1){1'b0}}, 1'b1};

  logic [IDX_W-1:0] pos_s;

  // Scan from the farthest offset down so the nearest requester is the last writer.
  always_comb begin
    idx   = '0;
    any   = 1'b0;
    pos_s = '0;
    for (int i = N - 1; i >= 0; i--) begin
      pos_s = IDX_W'((int'(ptr) + i) % N);
      idx   = req[pos_s] ? pos_s : idx;
      any   = req[pos_s] ? 1'b1 : any;
    end
  end

  // Expand the winning index into a one-hot grant.
  always_comb begin
    if (any) begin
      gnt = ONE_HOT_LSB << idx;
    end else begin
      gnt = '0;
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ byte sources,
// with busy-rise timeout and a programmable post-frame idle gap.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int GAP_CYCLES = 16,
  parameter int BUSY_TMO   = 64,
  localparam int ID_W      = clog2(N_REQ)
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [N_REQ-1:0]             i_req_valid,
  input  logic [UART_DATA_W*N_REQ-1:0] i_req_data,
  output logic [N_REQ-1:0]             o_req_ready,
  output logic                         o_tx_start,
  output logic [UART_DATA_W-1:0]       o_tx_data,
  input  logic                         i_tx_busy,
  output logic [ID_W-1:0]              o_grant_id,
  output logic                         o_busy,
  output logic                         o_timeout
);

  localparam int CNT_MAX = (GAP_CYCLES > BUSY_TMO) ? GAP_CYCLES : BUSY_TMO;
  localparam int CNT_W   = clog2(CNT_MAX + 1);

  tx_state_e              state_r;
  tx_state_e              state_nxt_s;
  logic [ID_W-1:0]        rr_ptr_r;
  logic [ID_W-1:0]        rr_ptr_nxt_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [UART_DATA_W-1:0] tx_data_r;
  logic [ID_W-1:0]        grant_id_r;
  logic                   tx_start_r;
  logic                   busy_r;
  logic [N_REQ-1:0]       gnt_s;
  logic [ID_W-1:0]        idx_s;
  logic                   any_s;
  logic                   xfer_s;
  logic                   tmo_hit_s;
  logic                   gap_hit_s;
  logic                   timeout_s;
  logic [UART_DATA_W-1:0] data_sel_s;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_rr_arbiter (
    .req (i_req_valid),
    .ptr (rr_ptr_r),
    .gnt (gnt_s),
    .idx (idx_s),
    .any (any_s)
  );

  // Ready is only offered while idle and out of reset, so ready&valid equals the grant.
  assign o_req_ready  = ((state_r == ST_IDLE) && i_reset) ? gnt_s : '0;
  assign xfer_s       = (state_r == ST_IDLE) && i_reset && any_s;
  assign tmo_hit_s    = (cnt_r == CNT_W'(BUSY_TMO - 1));
  assign gap_hit_s    = (cnt_r == CNT_W'(GAP_CYCLES - 1));
  assign rr_ptr_nxt_s = (idx_s == ID_W'(N_REQ - 1)) ? '0 : idx_s + ID_W'(1);

  // Select the granted source's byte with an AND-OR mux over the one-hot grant.
  always_comb begin
    data_sel_s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      data_sel_s = data_sel_s |
                   ({UART_DATA_W{gnt_s[k]}} & i_req_data[k*UART_DATA_W +: UART_DATA_W]);
    end
  end

  // Next-state logic and the timeout pulse.
  always_comb begin
    state_nxt_s = state_r;
    timeout_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        state_nxt_s = xfer_s ? ST_LAUNCH : ST_IDLE;
      end
      ST_LAUNCH: begin
        state_nxt_s = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (i_tx_busy) begin
          state_nxt_s = ST_WAIT_DONE;
        end else if (tmo_hit_s) begin
          timeout_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_DONE: begin
        if (!i_tx_busy) begin
          state_nxt_s = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end else begin
          state_nxt_s = ST_WAIT_DONE;
        end
      end
      ST_GAP: begin
        state_nxt_s = gap_hit_s ? ST_IDLE : ST_GAP;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register, shared counter, data latch and registered status outputs.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_r    <= ST_IDLE;
      rr_ptr_r   <= '0;
      cnt_r      <= '0;
      tx_data_r  <= '0;
      grant_id_r <= '0;
      tx_start_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      tx_start_r <= (state_nxt_s == ST_LAUNCH);
      busy_r     <= (state_nxt_s != ST_IDLE);
      if (state_nxt_s != state_r) begin
        cnt_r <= '0;
      end else if ((state_r == ST_WAIT_BUSY) || (state_r == ST_GAP)) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= '0;
      end
      if (xfer_s) begin
        tx_data_r  <= data_sel_s;
        grant_id_r <= idx_s;
        rr_ptr_r   <= rr_ptr_nxt_s;
      end else begin
        tx_data_r  <= tx_data_r;
        grant_id_r <= grant_id_r;
        rr_ptr_r   <= rr_ptr_r;
      end
    end
  end

  assign o_tx_start = tx_start_r;
  assign o_tx_data  = tx_data_r;
  assign o_grant_id = grant_id_r;
  assign o_busy     = busy_r;
  assign o_timeout  = timeout_s;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: random sources and a transmitter model,
// checked against a cycle-level reference of the arbitration rules.
module tb_uart_tx_arb;

  localparam int N   = 4;
  localparam int GAP = 16;
  localparam int TMO = 64;
  localparam int BIG = 32'h7fff_ffff;

  logic           clk;
  logic           i_reset;
  logic [N-1:0]   i_req_valid;
  logic [8*N-1:0] i_req_data;
  logic [N-1:0]   o_req_ready;
  logic           o_tx_start;
  logic [7:0]     o_tx_data;
  logic           i_tx_busy;
  logic [1:0]     o_grant_id;
  logic           o_busy;
  logic           o_timeout;

  logic [N-1:0]   z_valid;
  logic [8*N-1:0] z_data_bus;
  logic [N-1:0]   z_ready;
  logic           z_start;
  logic [7:0]     z_tx_data;
  logic           z_busy_in;
  logic [1:0]     z_gid;
  logic           z_busy;
  logic           z_tmo;

  uart_tx_arb #(.N_REQ(N), .GAP_CYCLES(GAP), .BUSY_TMO(TMO)) u_dut (
    .i_clk(clk), .i_reset(i_reset), .i_req_valid(i_req_valid), .i_req_data(i_req_data),
    .o_req_ready(o_req_ready), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
    .i_tx_busy(i_tx_busy), .o_grant_id(o_grant_id), .o_busy(o_busy), .o_timeout(o_timeout)
  );

  uart_tx_arb #(.N_REQ(N), .GAP_CYCLES(0), .BUSY_TMO(TMO)) u_dut_g0 (
    .i_clk(clk), .i_reset(i_reset), .i_req_valid(z_valid), .i_req_data(z_data_bus),
    .o_req_ready(z_ready), .o_tx_start(z_start), .o_tx_data(z_tx_data),
    .i_tx_busy(z_busy_in), .o_grant_id(z_gid), .o_busy(z_busy), .o_timeout(z_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // knobs (main), shared plan (monitor -> driver), acceptance counts (monitor -> driver)
  logic [N-1:0] mask = '0;
  int  load_pct = 0, len_fix = 20, tmo_pct = 0;
  bit  force_a5 = 1'b0, done = 1'b0, mid_ok = 1'b0;
  int  bon = 0, boff = 0, z_bon = 0, z_boff = 0, z_acc = 0;
  int  acc_cnt [N] = '{default: 0};
  int  seen_cnt[N] = '{default: 0};
  logic [7:0] offer[N];

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // stimulus: sources hold valid until accepted; transmitter follows the monitor's plan
  initial begin
    i_req_valid = '0; i_req_data = '0; i_tx_busy = 1'b0;
    z_valid = 4'b0010; z_data_bus = '0; z_busy_in = 1'b0;
    forever begin
      @(posedge clk); #1;
      i_tx_busy = (cyc >= bon) && (cyc < boff);
      z_busy_in = (cyc >= z_bon) && (cyc < z_boff);
      z_data_bus[15:8] = 8'h3C + 8'(17 * z_acc);
      for (int k = 0; k < N; k++) begin
        if (acc_cnt[k] != seen_cnt[k]) begin
          seen_cnt[k] = acc_cnt[k];
          i_req_valid[k] = 1'b0;
        end
        if (!i_req_valid[k] && mask[k] && int'($urandom_range(99)) < load_pct) begin
          offer[k] = force_a5 ? 8'hA5 : 8'($urandom);
          i_req_data[8*k +: 8] = offer[k];
          i_req_valid[k] = 1'b1;
        end
      end
    end
  end

  // monitor + reference model: rotating pointer, frame windows, gap and timeout arithmetic
  initial begin
    int m_ptr, m_free_at, m_start_at, m_tmo_at, win, k, dly, len, rst_cycles;
    int frames, n_tmo, z_free_at, z_start_at, z_frames, cur_id;
    bit m_active, z_active, cur_ok;
    logic [N-1:0] exp_rdy;
    logic [7:0] d, cur_data;
    int lq_id[$];
    logic [7:0] lq_data[$];
    m_ptr = 0; m_free_at = BIG; m_start_at = -1; m_tmo_at = -1; rst_cycles = 0;
    frames = 0; n_tmo = 0; z_free_at = BIG; z_start_at = -1; z_frames = 0;
    m_active = 1'b0; z_active = 1'b0; cur_ok = 1'b0; cur_id = 0; cur_data = '0;
    forever begin
      @(negedge clk);
      if (!i_reset) begin
        if (rst_cycles > 0) begin
          chk("rst_ready", 32'(o_req_ready), 32'd0);
          chk("rst_tx_start", 32'(o_tx_start), 32'd0);
          chk("rst_tx_data", 32'(o_tx_data), 32'd0);
          chk("rst_grant_id", 32'(o_grant_id), 32'd0);
          chk("rst_busy", 32'(o_busy), 32'd0);
          chk("rst_timeout", 32'(o_timeout), 32'd0);
          chk("z_rst_busy", 32'(z_busy), 32'd0);
        end
        chk("rst_ready_forced", 32'(o_req_ready), 32'd0);
        chk("z_rst_ready_forced", 32'(z_ready), 32'd0);
        rst_cycles++;
        m_ptr = 0; m_active = 1'b0; m_free_at = BIG; m_start_at = -1; m_tmo_at = -1;
        bon = 0; boff = 0; cur_ok = 1'b0;
        lq_id.delete(); lq_data.delete();
        z_active = 1'b0; z_free_at = BIG; z_start_at = -1; z_bon = 0; z_boff = 0;
      end else begin
        if (rst_cycles > 0) begin
          m_free_at = cyc; z_free_at = cyc; rst_cycles = 0;
        end
        // main instance
        chk("tx_start", 32'(o_tx_start), 32'(cyc == m_start_at));
        chk("timeout", 32'(o_timeout), 32'(cyc == m_tmo_at));
        if (cyc == m_tmo_at) n_tmo++;
        chk("busy", 32'(o_busy), 32'(m_active || cyc < m_free_at));
        if (cur_ok && cyc < m_free_at) begin
          chk("tx_data_hold", 32'(o_tx_data), 32'(cur_data));
          chk("grant_id_hold", 32'(o_grant_id), 32'(cur_id));
        end
        if (cyc == m_start_at && lq_id.size() > 0) begin
          cur_id = lq_id.pop_front();
          cur_data = lq_data.pop_front();
          chk("tx_data", 32'(o_tx_data), 32'(cur_data));
          chk("grant_id", 32'(o_grant_id), 32'(cur_id));
          frames++;
          if (int'($urandom_range(99)) < tmo_pct) begin
            m_tmo_at = cyc + TMO; m_free_at = cyc + TMO + 1;
            bon = 0; boff = 0; cur_ok = 1'b0;
          end else begin
            dly = int'($urandom_range(3));
            len = (len_fix > 0) ? len_fix : int'($urandom_range(40, 2));
            bon = cyc + 1 + dly; boff = bon + len;
            m_free_at = boff + 1 + GAP; cur_ok = 1'b1;
          end
          m_active = 1'b0;
        end
        exp_rdy = '0; win = -1;
        if (!m_active && cyc >= m_free_at) begin
          for (int i = 0; i < N; i++) begin
            k = (m_ptr + i) % N;
            if (win < 0 && i_req_valid[k]) win = k;
          end
        end
        if (win >= 0) exp_rdy[win] = 1'b1;
        chk("req_ready", 32'(o_req_ready), 32'(exp_rdy));
        if (win >= 0) begin
          lq_id.push_back(win);
          lq_data.push_back(offer[win]);
          m_ptr = (win + 1) % N; m_active = 1'b1; m_start_at = cyc + 1;
          acc_cnt[win]++;
        end
        // zero-gap instance, single source 1 always valid
        chk("z_tx_start", 32'(z_start), 32'(cyc == z_start_at));
        chk("z_busy", 32'(z_busy), 32'(z_active || cyc < z_free_at));
        chk("z_timeout", 32'(z_tmo), 32'd0);
        if (cyc == z_start_at) begin
          d = 8'h3C + 8'(17 * (z_acc - 1));
          chk("z_tx_data", 32'(z_tx_data), 32'(d));
          chk("z_grant_id", 32'(z_gid), 32'd1);
          z_bon = cyc + 1; z_boff = z_bon + 2 + int'($urandom_range(4));
          z_free_at = z_boff + 1; z_active = 1'b0; z_frames++;
        end
        exp_rdy = (!z_active && cyc >= z_free_at) ? 4'b0010 : 4'b0000;
        chk("z_ready", 32'(z_ready), 32'(exp_rdy));
        if (exp_rdy != 4'b0000) begin
          z_active = 1'b1; z_start_at = cyc + 1; z_acc++;
        end
      end
      if (done) begin
        chk("frames_served", 32'(frames >= 30), 32'd1);
        chk("timeouts_seen", 32'(n_tmo > 0), 32'd1);
        chk("midframe_reset_reached", 32'(mid_ok), 32'd1);
        chk("zero_gap_frames", 32'(z_frames >= 10), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
      end
    end
  end

  // scenario sequencing
  initial begin
    i_reset = 1'b0;
    repeat (4) @(posedge clk);
    #1 i_reset = 1'b1;
    // single source 2 offering 8'hA5
    #2 force_a5 = 1'b1; mask = 4'b0100; load_pct = 100; len_fix = 20;
    @(posedge clk); #3 mask = 4'b0000;
    repeat (150) @(posedge clk);
    // all sources continuously valid, 100-cycle frames
    #3 force_a5 = 1'b0; mask = 4'b1111; load_pct = 100; len_fix = 100;
    repeat (750) @(posedge clk);
    // random traffic with timeouts
    #3 load_pct = 15; len_fix = 0; tmo_pct = 15;
    repeat (6000) @(posedge clk);
    // reset while the transmitter is mid-frame
    #3 tmo_pct = 0;
    for (int i = 0; i < 3000 && !mid_ok; i++) begin
      @(posedge clk); #2;
      if (i_tx_busy && cyc > bon) begin
        i_reset = 1'b0;
        mid_ok = 1'b1;
      end
    end
    repeat (2) @(posedge clk);
    #1 i_reset = 1'b1;
    repeat (1500) @(posedge clk);
    #3 tmo_pct = 15;
    repeat (1500) @(posedge clk);
    #3 done = 1'b1;
  end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin scheduler that shares one UART transmitter among `N_REQ` byte sources. Each source offers a byte on a valid/ready handshake. The block picks the next source in rotating order, launches the transmitter with a one-cycle start pulse, and tracks frame completion from the transmitter's busy flag. It then enforces a programmable idle gap before the next frame. It sits between the board-level message sources (switch capture, status reporter, debug console) and the serial transmitter.

## Interface
- `N_REQ`, 4: number of requesters; range 2–8.
- `GAP_CYCLES`, 16: `i_clk` cycles of enforced line idle after each frame; 0 disables the gap.
- `BUSY_TMO`, 64: cycles to wait for `i_tx_busy` to rise after a start pulse before aborting.
- `i_clk`, in, 1: sole clock.
- `i_reset`, in, 1: synchronous, active-low reset.
- `i_req_valid`, in, N_REQ: per-source byte offered.
- `i_req_data`, in, 8*N_REQ: source k byte on bits [8k+7:8k].
- `o_req_ready`, out, N_REQ: one-hot acceptance; the byte transfers on the edge where valid&ready.
- `o_tx_start`, out, 1: one-cycle launch pulse to the transmitter.
- `o_tx_data`, out, 8: byte to serialize; held stable from launch until the frame completes.
- `i_tx_busy`, in, 1: transmitter is sending a frame (start through stop bit).
- `o_grant_id`, out, clog2(N_REQ): index of the source whose byte is in flight.
- `o_busy`, out, 1: high in every state except IDLE.
- `o_timeout`, out, 1: one-cycle pulse when `BUSY_TMO` expires.

## Operation
- Registered FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP.
- **IDLE:** `o_req_ready` is driven combinationally, one-hot, to the first requester with valid=1, searching from pointer `rr_ptr` upward and wrapping modulo N_REQ. If no source is valid, ready is 0.
  - On transfer, latch the byte into `o_tx_data` and the index into `o_grant_id`.
  - Set `rr_ptr` to winner+1, wrapping from N_REQ-1 to 0.
  - Go to LAUNCH.
- **LAUNCH:** `o_tx_start`=1 for exactly this one cycle. Go to WAIT_BUSY.
- **WAIT_BUSY:** when `i_tx_busy`=1, go to WAIT_DONE.
  - If the timeout counter reaches `BUSY_TMO` first, pulse `o_timeout`, drop the byte, and go to IDLE; the gap is skipped.
- **WAIT_DONE:** when `i_tx_busy`=0, go to GAP, or to IDLE if `GAP_CYCLES`=0.
- **GAP:** count `GAP_CYCLES` cycles, then go to IDLE.
- `o_req_ready` is 0 in every state except IDLE.
- Sources must hold valid and data stable until ready. The block does not require this, but a source that drops valid simply loses arbitration.
- A source with valid held continuously is served at most once per rotation while any other source is valid. This guarantees fairness.
- A single active source is served back-to-back, separated only by the frame time plus the gap.
- Gap and timeout counters are wide enough for max(GAP_CYCLES, BUSY_TMO). Each is cleared on entry to its state.
- **Reset** (`i_reset`=0 at a clock edge), including mid-frame:
  - State goes to IDLE and `rr_ptr` to 0.
  - Counters clear and the in-flight byte is abandoned.
  - `o_req_ready` is forced to 0 while reset is low.

## Timing
- Reset values:
  - `o_tx_start`=0, `o_tx_data`=8'h00, `o_grant_id`=0.
  - `o_busy`=0, `o_timeout`=0, `o_req_ready`=0.
- Handshake cycle is c0. `o_tx_start` is high in c1. `o_busy` is high from c1.
- Earliest next ready is one cycle after the block observes `i_tx_busy` falling, plus `GAP_CYCLES`.
- Timeout pulse occurs `BUSY_TMO` cycles after LAUNCH; `o_busy` falls the cycle after.
- If `i_tx_busy` is already high in LAUNCH, WAIT_BUSY exits on its first cycle.

## Structure
- Shared package `uart_pkg`: FSM state enum, `UART_DATA_W`=8, and a clog2 helper function.
- Sub-module `rr_arbiter`: combinational rotating-priority pick.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant, index, and any-request flag.
- The FSM, counters and data latch live in `uart_tx_arb`.

## Test plan
- **Single source:** reset, then source 2 valid with 8'hA5 → ready[2] in c0, `o_tx_start` in c1, `o_tx_data`=8'hA5, `o_grant_id`=2.
- **Fairness:** all four valid continuously, transmitter model busy for 100 cycles per frame → grant order 0,1,2,3,0 with `GAP_CYCLES`=16 idle between busy-fall and next ready.
- **Wrap:** `rr_ptr`=3 with sources 1 and 3 valid → 3 served, then 1; `rr_ptr` wraps to 0 after serving 3.
- **Timeout:** `i_tx_busy` held 0 after launch → `o_timeout` pulses exactly 64 cycles after LAUNCH, then returns to IDLE with no gap.
- **Mid-frame reset:** assert `i_reset`=0 in WAIT_DONE → next cycle all outputs at reset values and `rr_ptr`=0; first grant after release goes to the lowest valid index.
- **Zero gap:** `GAP_CYCLES`=0 → ready reasserts the cycle after `i_tx_busy` falls.
